// File: rtl/nec_ir_tx.sv
// -----------------------------------------------------------------------------
// nec_ir_tx -- NEC-protocol infrared transmitter.
//
// On an accepted start strobe the block latches an 8-bit address and command
// and sends one full NEC frame: a 16-unit leader mark and an 8-unit leader
// space, then 32 data bits {~cmd, cmd, ~addr, addr} LSB first, then a 1-unit
// stop mark. It then holds a space until the frame period (FRAME_UNITS units,
// counted from the start of the leader) has elapsed. Each data bit is a 1-unit
// mark followed by a 1-unit space (bit 0) or a 3-unit space (bit 1). Marks are
// gated with a carrier of roughly 38 kHz and 1/3 duty.
//
// Optional feature (define IR_REPEAT_EN): if tx_repeat is high when the frame
// period ends, the block sends NEC repeat frames (16-unit mark, 4-unit space,
// 1-unit stop mark, then gap to the frame period) instead of finishing. done
// pulses only after the last frame.
//
// Ports
//   clk50m     in   1  system clock, 50 MHz
//   reset_n    in   1  asynchronous active-low reset
//   tx_start   in   1  send request, accepted only while idle and not on done
//   tx_addr    in   8  NEC address, latched on accept
//   tx_cmd     in   8  NEC command, latched on accept
//   tx_repeat  in   1  repeat-code request (IR_REPEAT_EN builds only)
//   busy       out  1  high from the cycle after accept to the end of the frame
//   done       out  1  one-cycle pulse when the last frame period ends
//   ir_env     out  1  unmodulated envelope, 1 = mark
//   ir_out     out  1  LED drive, envelope AND carrier (registered)
// -----------------------------------------------------------------------------
module nec_ir_tx #(
    parameter int unsigned TICK_CYCLES  = 28125, // clk cycles per NEC unit
    parameter int unsigned CARRIER_DIV  = 1316,  // clk cycles per carrier period
    parameter int unsigned CARRIER_HIGH = 439,   // carrier high cycles, < CARRIER_DIV
    parameter int unsigned FRAME_UNITS  = 192    // frame period in units
) (
    input  logic       clk50m,
    input  logic       reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
    input  logic       tx_repeat,
    output logic       busy,
    output logic       done,
    output logic       ir_env,
    output logic       ir_out
);

    localparam int TICK_W = $clog2(TICK_CYCLES + 1);
    localparam int CARR_W = $clog2(CARRIER_DIV + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
    localparam logic [CARR_W-1:0] CARR_LAST  = CARR_W'(CARRIER_DIV - 1);
    localparam logic [CARR_W-1:0] CARR_HI    = CARR_W'(CARRIER_HIGH);
    localparam logic [7:0]        FRAME_LAST = 8'(FRAME_UNITS - 1);

`ifdef IR_REPEAT_EN
    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP, RPT_SPACE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   unit_cnt_q;   // clk cycles within the current unit
    logic [4:0]          unit_idx_q;   // units completed within the current state
    logic [7:0]          frame_cnt_q;  // units completed since leader start
    logic [4:0]          bit_idx_q;    // data bit being sent
    logic [CARR_W-1:0]   carr_q, carr_d;
    logic [31:0]         data_q;

    logic                unit_end;
    logic                state_end;
    logic [4:0]          unit_last;    // duration of the current state, minus one
    logic                accept;
    logic                done_d;
    logic                enter;        // next cycle is the first of a new state
    logic                mark_d;

`ifdef IR_REPEAT_EN
    logic                rpt_q, rpt_d; // current frame is a repeat frame
`else
    logic                unused_repeat;
    assign unused_repeat = tx_repeat;
`endif

    assign unit_end = (unit_cnt_q == TICK_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        state_d   = state_q;
        accept    = 1'b0;
        done_d    = 1'b0;
        unit_last = 5'd0;
`ifdef IR_REPEAT_EN
        rpt_d     = rpt_q;
`endif

        case (state_q)
            LEAD_MARK:  unit_last = 5'd15;
            LEAD_SPACE: unit_last = 5'd7;
            BIT_SPACE:  unit_last = data_q[bit_idx_q] ? 5'd2 : 5'd0;
`ifdef IR_REPEAT_EN
            RPT_SPACE:  unit_last = 5'd3;
`endif
            default:    unit_last = 5'd0;
        endcase

        state_end = unit_end && (unit_idx_q == unit_last);

        case (state_q)
            IDLE: begin
                // The done cycle is still idle but must not accept a new frame.
                if (tx_start && !done) begin
                    state_d = LEAD_MARK;
                    accept  = 1'b1;
`ifdef IR_REPEAT_EN
                    rpt_d   = 1'b0;
`endif
                end
            end
            LEAD_MARK: begin
                if (state_end) begin
`ifdef IR_REPEAT_EN
                    state_d = rpt_q ? RPT_SPACE : LEAD_SPACE;
`else
                    state_d = LEAD_SPACE;
`endif
                end
            end
            LEAD_SPACE: if (state_end) state_d = BIT_MARK;
            BIT_MARK:   if (state_end) state_d = BIT_SPACE;
            BIT_SPACE:  if (state_end) state_d = (bit_idx_q == 5'd31) ? STOP_MARK : BIT_MARK;
`ifdef IR_REPEAT_EN
            RPT_SPACE:  if (state_end) state_d = STOP_MARK;
`endif
            STOP_MARK:  if (state_end) state_d = GAP;
            GAP: begin
                if (unit_end && frame_cnt_q == FRAME_LAST) begin
`ifdef IR_REPEAT_EN
                    if (tx_repeat) begin
                        state_d = LEAD_MARK;
                        rpt_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter  = (state_d != state_q);
    assign mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

    // The carrier restarts on every mark entry so each mark opens with a high phase.
    always_comb begin
        if (state_d == IDLE || (enter && mark_d)) begin
            carr_d = '0;
        end else if (carr_q == CARR_LAST) begin
            carr_d = '0;
        end else begin
            carr_d = carr_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            unit_cnt_q  <= '0;
            unit_idx_q  <= '0;
            frame_cnt_q <= '0;
            bit_idx_q   <= '0;
            carr_q      <= '0;
            data_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ir_env      <= 1'b0;
            ir_out      <= 1'b0;
`ifdef IR_REPEAT_EN
            rpt_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            carr_q  <= carr_d;

            if (state_d == IDLE || enter || unit_end) begin
                unit_cnt_q <= '0;
            end else begin
                unit_cnt_q <= unit_cnt_q + 1'b1;
            end

            if (enter) begin
                unit_idx_q <= '0;
            end else if (unit_end) begin
                unit_idx_q <= unit_idx_q + 1'b1;
            end

            if (enter && state_d == LEAD_MARK) begin
                frame_cnt_q <= '0;
            end else if (unit_end) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end

            // Advances once per finished bit; wraps back to 0 after bit 31.
            if (state_q == BIT_SPACE && enter) begin
                bit_idx_q <= bit_idx_q + 1'b1;
            end

            if (accept) begin
                data_q <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
            end

            busy   <= (state_d != IDLE);
            done   <= done_d;
            ir_env <= mark_d;
            ir_out <= mark_d && (carr_d < CARR_HI);
`ifdef IR_REPEAT_EN
            rpt_q  <= rpt_d;
`endif
        end
    end

endmodule

// File: tb/tb_nec_ir_tx.sv
// -----------------------------------------------------------------------------
// tb_nec_ir_tx -- self-checking bench for nec_ir_tx.
//
// Cycle numbering: cycle 0 is the cycle in which tx_start is sampled high and
// accepted; outputs are sampled on the falling edge of each following cycle.
// The reference model builds the expected envelope and LED waveform directly
// from the NEC segment list (mark/space durations in units).
// -----------------------------------------------------------------------------
module tb_nec_ir_tx;

    localparam int TICK      = 10;
    localparam int DIV       = 4;
    localparam int HIGH      = 1;
    localparam int FRAME     = 192;
    localparam int FRAME_CYC = FRAME * TICK;
    localparam int MAXC      = 6400;

    logic       clk50m    = 1'b0;
    logic       reset_n   = 1'b0;
    logic       tx_start  = 1'b0;
    logic       tx_repeat = 1'b0;
    logic [7:0] tx_addr   = 8'h00;
    logic [7:0] tx_cmd    = 8'h00;
    logic       busy, done, ir_env, ir_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic env_t [MAXC];
    logic out_t [MAXC];
    logic done_t[MAXC];
    logic busy_t[MAXC];
    logic env_x [MAXC];
    logic out_x [MAXC];
    int   done_x;

    nec_ir_tx #(
        .TICK_CYCLES (TICK),
        .CARRIER_DIV (DIV),
        .CARRIER_HIGH(HIGH),
        .FRAME_UNITS (FRAME)
    ) dut (
        .clk50m   (clk50m),
        .reset_n  (reset_n),
        .tx_start (tx_start),
        .tx_addr  (tx_addr),
        .tx_cmd   (tx_cmd),
        .tx_repeat(tx_repeat),
        .busy     (busy),
        .done     (done),
        .ir_env   (ir_env),
        .ir_out   (ir_out)
    );

    always #5 clk50m = ~clk50m;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Expected waveform: one full frame followed by nrep repeat frames.
    task automatic build_model(input logic [7:0] a, input logic [7:0] c, input int nrep);
        int          cyc;
        int          fstart;
        int          seg_mark[$];
        int          seg_units[$];
        logic [31:0] w;
        for (int i = 0; i < MAXC; i++) begin
            env_x[i] = 1'b0;
            out_x[i] = 1'b0;
        end
        w   = {~c, c, ~a, a};
        cyc = 1;
        for (int f = 0; f <= nrep; f++) begin
            seg_mark.delete();
            seg_units.delete();
            seg_mark.push_back(1); seg_units.push_back(16);
            if (f == 0) begin
                seg_mark.push_back(0); seg_units.push_back(8);
                for (int b = 0; b < 32; b++) begin
                    seg_mark.push_back(1); seg_units.push_back(1);
                    seg_mark.push_back(0); seg_units.push_back(w[b] ? 3 : 1);
                end
            end else begin
                seg_mark.push_back(0); seg_units.push_back(4);
            end
            seg_mark.push_back(1); seg_units.push_back(1);
            fstart = cyc;
            for (int s = 0; s < seg_mark.size(); s++) begin
                for (int k = 0; k < seg_units[s] * TICK; k++) begin
                    env_x[cyc] = (seg_mark[s] == 1);
                    out_x[cyc] = (seg_mark[s] == 1) && ((k % DIV) < HIGH);
                    cyc++;
                end
            end
            cyc = fstart + FRAME_CYC;
        end
        done_x = cyc;
    endtask

    // Starts a frame and records outputs for cycles 1..ncyc. Data inputs are
    // scrambled while busy; reject_at pulses tx_start with cmd 0x12 in that
    // cycle; tx_repeat stays high in cycles below rpt_until; hold keeps
    // tx_start high throughout.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input int ncyc,
                             input int reject_at, input int rpt_until, input bit hold);
        @(negedge clk50m);
        tx_addr   = a;
        tx_cmd    = c;
        tx_start  = 1'b1;
        tx_repeat = (rpt_until > 0);
        @(posedge clk50m);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk50m);
            env_t[i]  = ir_env;
            out_t[i]  = ir_out;
            done_t[i] = done;
            busy_t[i] = busy;
            tx_addr   = 8'($urandom);
            tx_cmd    = (i == reject_at) ? 8'h12 : 8'($urandom);
            tx_start  = hold || (i == reject_at);
            tx_repeat = (i < rpt_until);
        end
        tx_start  = 1'b0;
        tx_repeat = 1'b0;
    endtask

    function automatic int first_bad(input int upto, input int sel);
        logic got, want;
        for (int i = 1; i <= upto; i++) begin
            case (sel)
                0:       begin got = env_t[i];  want = env_x[i]; end
                1:       begin got = out_t[i];  want = out_x[i]; end
                default: begin got = busy_t[i]; want = (i < done_x); end
            endcase
            if (got !== want) return i;
        end
        return -1;
    endfunction

    function automatic int done_count(input int upto, output int first_pos);
        int n;
        n = 0;
        first_pos = -1;
        for (int i = 1; i <= upto; i++) begin
            if (done_t[i] === 1'b1) begin
                if (n == 0) first_pos = i;
                n++;
            end
        end
        return n;
    endfunction

    // Reads the data word back from the recorded envelope by space length.
    function automatic logic [31:0] decode_word();
        logic [31:0] w;
        int          pos;
        int          len;
        w   = '0;
        pos = 241;
        for (int b = 0; b < 32; b++) begin
            pos += TICK;
            len = 0;
            while (pos < MAXC && env_t[pos] === 1'b0 && len < 100) begin
                len++;
                pos++;
            end
            w[b] = (len > 2 * TICK);
        end
        return w;
    endfunction

    task automatic drain(input string tag);
        int k;
        k = 0;
        tx_start  = 1'b0;
        tx_repeat = 1'b0;
        while (busy !== 1'b0 && k < 5000) begin
            @(negedge clk50m);
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: busy got %b want 0 within 5000 cycles", tag, busy);
        end
        repeat (3) @(negedge clk50m);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk50m);
        n_checks++;
        if ({busy, done, ir_env, ir_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle: {busy,done,env,out} got %b want 0000",
                     {busy, done, ir_env, ir_out});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk50m);
        tx_addr  = 8'hA5;
        tx_cmd   = 8'h3C;
        tx_start = 1'b1;
        @(posedge clk50m);
        @(negedge clk50m);
        tx_start = 1'b0;
        repeat (48) @(negedge clk50m);
        // Cycle 49 of the leader: carrier phase 0, so the LED is on.
        n_checks++;
        if ({busy, ir_env, ir_out} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_pre_lead: {busy,env,out} got %b want 111", {busy, ir_env, ir_out});
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, ir_env, ir_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: {busy,done,env,out} got %b want 0000",
                     {busy, done, ir_env, ir_out});
        end
        @(negedge clk50m);
        reset_n = 1'b1;
        repeat (20) @(negedge clk50m);
        n_checks++;
        if ({busy, done, ir_env, ir_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release_idle: {busy,done,env,out} got %b want 0000",
                     {busy, done, ir_env, ir_out});
        end
    endtask

    task automatic test_frame(input logic [7:0] a, input logic [7:0] c, input bit reject,
                              input string tag);
        int          bad;
        int          nd;
        int          dpos;
        logic [31:0] want_w;
        logic [31:0] got_w;
        logic        car_ok;
        run_frame(a, c, 1930, reject ? 500 : 0, 0, 1'b0);
        build_model(a, c, 0);
        want_w = {~c, c, ~a, a};

        bad = first_bad(1930, 0);
        n_checks++;
        if (bad != -1) begin
            n_fail++;
            $display("FAIL %s_env: cycle %0d got %b want %b", tag, bad, env_t[bad], env_x[bad]);
        end
        bad = first_bad(1930, 1);
        n_checks++;
        if (bad != -1) begin
            n_fail++;
            $display("FAIL %s_ir_out: cycle %0d got %b want %b", tag, bad, out_t[bad], out_x[bad]);
        end
        bad = first_bad(1930, 2);
        n_checks++;
        if (bad != -1) begin
            n_fail++;
            $display("FAIL %s_busy: cycle %0d got %b want %b", tag, bad, busy_t[bad], bad < done_x);
        end
        nd = done_count(1930, dpos);
        n_checks++;
        if (nd != 1 || dpos != 1921) begin
            n_fail++;
            $display("FAIL %s_done: got %0d pulses first at %0d want 1 pulse at 1921", tag, nd, dpos);
        end
        got_w = decode_word();
        n_checks++;
        if (got_w !== want_w) begin
            n_fail++;
            $display("FAIL %s_decode: got %h want %h", tag, got_w, want_w);
        end
        n_checks++;
        if ({env_t[1], env_t[160], env_t[161], env_t[240], env_t[241]} !== 5'b11001) begin
            n_fail++;
            $display("FAIL %s_leader: env@1,160,161,240,241 got %b want 11001", tag,
                     {env_t[1], env_t[160], env_t[161], env_t[240], env_t[241]});
        end
        n_checks++;
        if ({env_t[1210], env_t[1211]} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_stop_end: env@1210,1211 got %b want 10", tag,
                     {env_t[1210], env_t[1211]});
        end
        car_ok = 1'b1;
        for (int i = 1; i <= 160; i++) begin
            if (out_t[i] !== ((i - 1) % 4 == 0)) car_ok = 1'b0;
        end
        n_checks++;
        if (!car_ok) begin
            n_fail++;
            $display("FAIL %s_carrier: leader pattern got mismatch want 1,0,0,0 from cycle 1", tag);
        end
        drain(tag);
    endtask

    task automatic test_back_to_back();
        int         bad;
        int         nd;
        int         dpos;
        logic [7:0] a;
        logic [7:0] c;
        a = 8'($urandom);
        c = 8'($urandom);
        run_frame(a, c, 1930, 0, 0, 1'b1);
        build_model(a, c, 0);
        bad = first_bad(1921, 0);
        n_checks++;
        if (bad != -1) begin
            n_fail++;
            $display("FAIL b2b_env: cycle %0d got %b want %b", bad, env_t[bad], env_x[bad]);
        end
        nd = done_count(1930, dpos);
        n_checks++;
        if (nd != 1 || dpos != 1921) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d pulses first at %0d want 1 pulse at 1921", nd, dpos);
        end
        n_checks++;
        if ({busy_t[1922], env_t[1922], busy_t[1923], env_t[1923]} !== 4'b0011) begin
            n_fail++;
            $display("FAIL b2b_restart: busy/env@1922,1923 got %b want 0011",
                     {busy_t[1922], env_t[1922], busy_t[1923], env_t[1923]});
        end
        drain("b2b");
    endtask

    task automatic test_repeat();
        int         bad;
        int         nd;
        int         dpos;
        int         nrep;
        logic [7:0] a;
        logic [7:0] c;
        logic [1:0] want_edge;
        a = 8'($urandom);
        c = 8'($urandom);
`ifdef IR_REPEAT_EN
        nrep      = 2;
        want_edge = 2'b01;
`else
        nrep      = 0;
        want_edge = 2'b00;
`endif
        run_frame(a, c, 5770, 0, 4000, 1'b0);
        build_model(a, c, nrep);
        bad = first_bad(5770, 0);
        n_checks++;
        if (bad != -1) begin
            n_fail++;
            $display("FAIL repeat_env: cycle %0d got %b want %b", bad, env_t[bad], env_x[bad]);
        end
        bad = first_bad(5770, 1);
        n_checks++;
        if (bad != -1) begin
            n_fail++;
            $display("FAIL repeat_ir_out: cycle %0d got %b want %b", bad, out_t[bad], out_x[bad]);
        end
        bad = first_bad(5770, 2);
        n_checks++;
        if (bad != -1) begin
            n_fail++;
            $display("FAIL repeat_busy: cycle %0d got %b want %b", bad, busy_t[bad], bad < done_x);
        end
        nd = done_count(5770, dpos);
        n_checks++;
        if (nd != 1 || dpos != done_x) begin
            n_fail++;
            $display("FAIL repeat_done: got %0d pulses first at %0d want 1 pulse at %0d",
                     nd, dpos, done_x);
        end
        // Repeat-frame space-to-stop-mark edge (absent without the feature).
        n_checks++;
        if ({env_t[2120], env_t[2121]} !== want_edge) begin
            n_fail++;
            $display("FAIL repeat_stop_edge: env@2120,2121 got %b want %b",
                     {env_t[2120], env_t[2121]}, want_edge);
        end
        drain("repeat");
    endtask

    initial begin
        test_reset();
        test_frame(8'h00, 8'h45, 1'b0, "frame");
        test_frame(8'h00, 8'h45, 1'b1, "busy_reject");
        for (int n = 0; n < 3; n++) begin
            test_frame(8'($urandom), 8'($urandom), 1'b0, "rand_frame");
        end
        test_back_to_back();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
